pc_redirect_unit: RTL and testbench

- Consumer end of the branch/jump redirect interface: owns the fetch program counter and applies (PCSel, BranchPC) redirects from the ID-stage branch decision logic.
- Sequences PC through normal increment, hazard stall, and a redirect that arrives during a stall (deferred).
- Drives the IF/ID flush, a sticky misaligned-target flag and a taken-redirect counter.
- Sits between the instruction-memory address port and the IF/ID pipeline register.

---
 rtl/pc_redirect_unit.sv | 115 +++++++++++
 tb/tb_pc_redirect_unit.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/pc_redirect_unit.sv
// Fetch PC owner: applies branch/jump redirects, defers a redirect that arrives during a stall.
// Optional macro BRANCH_DELAY_SLOT_EN ties IFID_Flush low (delay-slot semantics).
module pc_redirect_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          COUNT_W  = 16
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               PCSel,
    input  logic [31:0]        BranchPC,
    input  logic               Stall,
    output logic [31:0]        PC,
    output logic [31:0]        PC_Plus_4,
    output logic               IFID_Flush,
    output logic               Redirect_Pending,
    output logic               Misalign_Err,
    output logic [COUNT_W-1:0] Redirect_Count
);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [31:0]          pc_q, pc_d;
    logic [31:0]          tgt_q, tgt_d;
    logic                 misalign_q, misalign_d;
    logic [COUNT_W-1:0]   count_q, count_d;
    logic                 apply_s;
    logic [31:0]          aligned_s;

    // Next-state logic for PC, deferred target, error flag and redirect counter
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        tgt_d      = tgt_q;
        misalign_d = misalign_q;
        count_d    = count_q;
        apply_s    = 1'b0;
        aligned_s  = {BranchPC[31:2], 2'b00};

        case (state_q)
            ST_RUN: begin
                if (PCSel) begin
                    if (BranchPC[1:0] != 2'b00) begin
                        misalign_d = 1'b1;
                    end else begin
                        misalign_d = misalign_q;
                    end
                    if (Stall) begin
                        // Branch is frozen in ID; remember its target until the stall lifts.
                        tgt_d   = aligned_s;
                        state_d = ST_HOLD;
                    end else begin
                        pc_d    = aligned_s;
                        apply_s = 1'b1;
                    end
                end else if (!Stall) begin
                    pc_d = pc_q + 32'd4;
                end else begin
                    pc_d = pc_q;
                end
            end
            ST_HOLD: begin
                if (!Stall) begin
                    pc_d    = tgt_q;
                    state_d = ST_RUN;
                    apply_s = 1'b1;
                end else begin
                    pc_d = pc_q;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        if (apply_s && (count_q != {COUNT_W{1'b1}})) begin
            count_d = count_q + {{(COUNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q    <= ST_RUN;
            pc_q       <= RESET_PC;
            tgt_q      <= 32'h0000_0000;
            misalign_q <= 1'b0;
            count_q    <= {COUNT_W{1'b0}};
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            tgt_q      <= tgt_d;
            misalign_q <= misalign_d;
            count_q    <= count_d;
        end
    end

    assign PC               = pc_q;
    assign PC_Plus_4        = pc_q + 32'd4;
    assign Redirect_Pending = (state_q == ST_HOLD);
    assign Misalign_Err     = misalign_q;
    assign Redirect_Count   = count_q;

`ifdef BRANCH_DELAY_SLOT_EN
    assign IFID_Flush = 1'b0;
`else
    assign IFID_Flush = Rst & apply_s;
`endif

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Self-checking bench for pc_redirect_unit: directed test-plan steps then random traffic vs a reference model.
module tb_pc_redirect_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          COUNT_W  = 16;

    logic               Clk;
    logic               Rst;
    logic               PCSel;
    logic [31:0]        BranchPC;
    logic               Stall;
    logic [31:0]        PC;
    logic [31:0]        PC_Plus_4;
    logic               IFID_Flush;
    logic               Redirect_Pending;
    logic               Misalign_Err;
    logic [COUNT_W-1:0] Redirect_Count;

    int errors = 0;
    int checks = 0;

    // Reference model: architectural state described directly from the rules
    logic [31:0] m_pc;
    logic [31:0] m_tgt;
    logic        m_pending;
    logic        m_mis;
    int          m_cnt;
    int          cnt_max;

    pc_redirect_unit #(.RESET_PC(RESET_PC), .COUNT_W(COUNT_W)) dut (
        .Clk(Clk), .Rst(Rst), .PCSel(PCSel), .BranchPC(BranchPC), .Stall(Stall),
        .PC(PC), .PC_Plus_4(PC_Plus_4), .IFID_Flush(IFID_Flush),
        .Redirect_Pending(Redirect_Pending), .Misalign_Err(Misalign_Err),
        .Redirect_Count(Redirect_Count)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check the combinational flush, advance model and DUT, check registers.
    task automatic step(input logic rst, input logic stall, input logic pcsel, input logic [31:0] bpc);
        logic exp_flush;
        Rst = rst; Stall = stall; PCSel = pcsel; BranchPC = bpc;
        #1;
        exp_flush = rst && !stall && (m_pending || pcsel);
`ifdef BRANCH_DELAY_SLOT_EN
        exp_flush = 1'b0;
`endif
        chk("flush", {31'b0, IFID_Flush}, {31'b0, exp_flush});
        @(posedge Clk);
        if (!rst) begin
            m_pc = RESET_PC; m_tgt = 32'h0; m_pending = 1'b0; m_mis = 1'b0; m_cnt = 0;
        end else if (m_pending) begin
            if (!stall) begin
                m_pc = m_tgt; m_pending = 1'b0;
                if (m_cnt < cnt_max) m_cnt = m_cnt + 1;
            end
        end else if (pcsel) begin
            if (bpc % 4 != 0) m_mis = 1'b1;
            if (stall) begin
                m_tgt = bpc - (bpc % 4); m_pending = 1'b1;
            end else begin
                m_pc = bpc - (bpc % 4);
                if (m_cnt < cnt_max) m_cnt = m_cnt + 1;
            end
        end else if (!stall) begin
            m_pc = m_pc + 32'd4;
        end
        #1;
        chk("pc", PC, m_pc);
        chk("pc_plus_4", PC_Plus_4, m_pc + 32'd4);
        chk("pending", {31'b0, Redirect_Pending}, {31'b0, m_pending});
        chk("misalign", {31'b0, Misalign_Err}, {31'b0, m_mis});
        chk("count", 32'(Redirect_Count), 32'(m_cnt));
    endtask

    initial begin
        cnt_max   = (1 << COUNT_W) - 1;
        m_pc      = RESET_PC;
        m_tgt     = 32'h0;
        m_pending = 1'b0;
        m_mis     = 1'b0;
        m_cnt     = 0;
        Rst = 1'b0; Stall = 1'b0; PCSel = 1'b0; BranchPC = 32'h0;

        // Reset, then sequential fetch 0x0 .. 0x10
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("reset_pc", PC, 32'h0000_0000);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("seq_pc_0x10", PC, 32'h0000_0010);

        // Immediate redirect to 0x400
        step(1'b1, 1'b0, 1'b1, 32'h0000_0400);
        chk("redirect_pc_0x400", PC, 32'h0000_0400);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("redirect_pc_0x404", PC, 32'h0000_0404);
        chk("redirect_count_1", 32'(Redirect_Count), 32'd1);

        // Redirect during stall: first capture wins
        step(1'b1, 1'b1, 1'b1, 32'h0000_0200);
        step(1'b1, 1'b1, 1'b1, 32'h0000_0300);
        step(1'b1, 1'b1, 1'b1, 32'h0000_0200);
        chk("hold_pc", PC, 32'h0000_0404);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("release_pc_0x200", PC, 32'h0000_0200);
        chk("release_count_2", 32'(Redirect_Count), 32'd2);

        // Misaligned target is truncated and flagged; flag is sticky
        step(1'b1, 1'b0, 1'b1, 32'h0000_0106);
        chk("misalign_pc_0x104", PC, 32'h0000_0104);
        step(1'b1, 1'b0, 1'b1, 32'h0000_0500);
        chk("misalign_sticky", {31'b0, Misalign_Err}, 32'd1);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("misalign_cleared", {31'b0, Misalign_Err}, 32'd0);

        // Reset while holding a deferred target
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b1, 32'h0000_0800);
        chk("hold_entered", {31'b0, Redirect_Pending}, 32'd1);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        chk("reset_in_hold_pc", PC, RESET_PC);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("no_late_jump", PC, RESET_PC + 32'd8);

        // PC wrap at the top of the address space
        step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
        chk("pc_top", PC, 32'hFFFF_FFFC);
        chk("pc_plus_4_wrap", PC_Plus_4, 32'h0000_0000);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("pc_wrap", PC, 32'h0000_0000);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 39) != 0),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 3) == 0),
                 $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
